// File: rtl/vr_packer.sv
`default_nettype none
// ============================================================================
//  Module   : vr_packer
//  Purpose  : Valid/ready width upsizer. Packs RATIO consecutive DATA_W-bit
//             beats into one DATA_W*RATIO-bit word. The first beat of a word
//             lands in lane 0 (LSBs). A beat carrying in_last closes the word
//             early; out_keep flags which lanes hold real beats.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous, active-low reset
//             in_valid  - input beat valid
//             in_ready  - input beat accepted when in_valid & in_ready
//             in_data   - input beat payload
//             in_last   - closes the current word after this beat
//             out_valid - packed word valid
//             out_ready - downstream accepts word when out_valid & out_ready
//             out_data  - packed word, lane k = [k*DATA_W +: DATA_W]
//             out_keep  - bit k set = lane k holds a real beat
//             fill      - lanes already written in the word being assembled
//  Revision : 1.0 - initial release
// ============================================================================
module vr_packer #(
  parameter  int DATA_W = 8,
  parameter  int RATIO  = 4,
  localparam int CNT_W  = $clog2(RATIO)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]        out_keep,
  output logic [CNT_W-1:0]        fill
);

  localparam logic [CNT_W-1:0] c_last_lane = CNT_W'(RATIO - 1);

  logic                    r_valid;
  logic [DATA_W*RATIO-1:0] r_data;
  logic [RATIO-1:0]        r_keep;
  logic [CNT_W-1:0]        r_fill;

  logic                    w_accept;
  logic                    w_pop;
  logic [CNT_W-1:0]        w_lane;
  logic                    w_close;
  logic [DATA_W*RATIO-1:0] w_data_nxt;
  logic [RATIO-1:0]        w_keep_nxt;

  // The held word can always leave in the same cycle a new beat arrives,
  // so readiness depends only on the output side.
  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_pop    = r_valid & out_ready;

  // A pop in the same cycle starts a fresh word, so the beat goes to lane 0.
  assign w_lane  = w_pop ? '0 : r_fill;
  assign w_close = (w_lane == c_last_lane) | in_last;

  // Next word contents: start from the current word (or a cleared one when
  // the current word is leaving) and drop the beat into the target lane.
  always_comb begin
    w_data_nxt = w_pop ? '0 : r_data;
    w_keep_nxt = w_pop ? '0 : r_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == w_lane) begin
        w_data_nxt[k*DATA_W +: DATA_W] = in_data;
        w_keep_nxt[k]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_fill  <= '0;
    end else if (w_accept) begin
      r_data  <= w_data_nxt;
      r_keep  <= w_keep_nxt;
      r_valid <= w_close;
      r_fill  <= w_close ? '0 : w_lane + CNT_W'(1);
    end else if (w_pop) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_fill  <= '0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_keep  = r_keep;
  assign fill      = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_vr_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vr_packer
//  Purpose  : Self-checking bench for vr_packer. Directed scenarios followed
//             by randomized traffic, checked against a queue-based model of
//             the word-packing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vr_packer;

  localparam int DATA_W = 8;
  localparam int RATIO  = 4;
  localparam int CNT_W  = $clog2(RATIO);

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]        out_keep;
  logic [CNT_W-1:0]        fill;

  vr_packer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats of the word being built, and closed words waiting
  // to be presented downstream.
  typedef struct {
    logic [DATA_W*RATIO-1:0] data;
    logic [RATIO-1:0]        keep;
  } word_t;

  logic [DATA_W-1:0] partial[$];
  word_t             pending[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic word_t build_word();
    word_t w;
    w.data = '0;
    w.keep = '0;
    foreach (partial[i]) begin
      w.data[i*DATA_W +: DATA_W] = partial[i];
      w.keep[i]                  = 1'b1;
    end
    return w;
  endfunction

  // One clock cycle. Called at a falling edge; drives inputs, checks the
  // DUT against the model, advances the model, and returns at the next
  // falling edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic l, input logic r);
    logic  exp_valid, exp_ready, acc, pop;
    word_t w;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    exp_valid = (pending.size() != 0);
    exp_ready = !exp_valid || r;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("in_ready",  64'(in_ready),  64'(exp_ready));
    chk("fill",      64'(fill),      64'(partial.size()));
    if (exp_valid) begin
      chk("out_data", 64'(out_data), 64'(pending[0].data));
      chk("out_keep", 64'(out_keep), 64'(pending[0].keep));
    end
    pop = exp_valid && r;
    acc = v && exp_ready;
    if (pop) void'(pending.pop_front());
    if (acc) begin
      partial.push_back(d);
      if (partial.size() == RATIO || l) begin
        w = build_word();
        pending.push_back(w);
        partial.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_keep",  64'(out_keep),  64'd0);
    chk("rst_fill",      64'(fill),      64'd0);
    partial.delete();
    pending.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Full word
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1);
    step(1, 8'h44, 0, 1);
    chk("tp_full_data", 64'(out_data),  64'h44332211);
    chk("tp_full_keep", 64'(out_keep),  64'hF);
    chk("tp_full_vld",  64'(out_valid), 64'd1);

    // Early flush via in_last; next beat lands in lane 0
    step(1, 8'hA1, 0, 1);
    step(1, 8'hA2, 1, 1);
    chk("tp_flush_data", 64'(out_data), 64'h0000A2A1);
    chk("tp_flush_keep", 64'(out_keep), 64'h3);
    step(1, 8'hB0, 0, 1);
    chk("tp_lane0_fill", 64'(fill), 64'd1);

    // Finish that word, then 8 back-to-back beats
    step(1, 8'hB1, 1, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 1);
      if (i == 4) chk("tp_b2b_w0", 64'(out_data), 64'h04030201);
      if (i == 8) chk("tp_b2b_w1", 64'(out_data), 64'h08070605);
    end

    // Backpressure for 5 cycles with a held word
    step(1, 8'h91, 0, 1);
    step(1, 8'h92, 0, 1);
    step(1, 8'h93, 0, 1);
    step(1, 8'h94, 0, 0);
    repeat (5) step(1, 8'hEE, 0, 0);
    chk("tp_hold_data", 64'(out_data), 64'h94939291);
    step(1, 8'hE0, 0, 1);
    chk("tp_hold_lane0", 64'(fill), 64'd1);

    // Pop coinciding with a single-beat last word
    step(1, 8'hE1, 0, 1);
    step(1, 8'hE2, 0, 1);
    step(1, 8'hE3, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'h5E, 1, 1);
    chk("tp_pop_last_data", 64'(out_data), 64'h0000005E);
    chk("tp_pop_last_keep", 64'(out_keep), 64'h1);

    // in_last without in_valid is ignored
    step(0, 8'h00, 0, 1);
    step(0, 8'h77, 1, 1);
    step(1, 8'h01, 0, 1);
    chk("tp_idle_last_fill", 64'(fill), 64'd1);

    // Reset mid-word
    step(1, 8'h02, 0, 1);
    do_reset();
    step(1, 8'hC1, 0, 1);
    step(1, 8'hC2, 0, 1);
    step(1, 8'hC3, 0, 1);
    step(1, 8'hC4, 0, 1);
    chk("tp_post_rst_data", 64'(out_data), 64'hC4C3C2C1);
    chk("tp_post_rst_keep", 64'(out_keep), 64'hF);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));
    end
    // Drain
    repeat (3) step(0, 8'h00, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
